pdes_ctrl: RTL and testbench

PDES_CTRL -- requirements
Module: pdes_ctrl

---
 rtl/pdes_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pdes_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdes_ctrl.sv
// Run controller for a bank of PDES simulation cores: AEG register file, run/finish/timeout
// sequencing, per-channel GVT minimum reduction and CSR read-back.
module pdes_ctrl #(
   parameter int NUM_CH = 4,
   parameter int NA     = 8,
   parameter int GVT_W  = 14
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      disp_inst_vld,
   input  logic [4:0]                disp_inst,
   input  logic [17:0]               disp_aeg_idx,
   input  logic                      disp_aeg_rd,
   input  logic                      disp_aeg_wr,
   input  logic [63:0]               disp_aeg_wr_data,
   output logic [17:0]               disp_aeg_cnt,
   output logic [15:0]               disp_exception,
   output logic                      disp_idle,
   output logic                      disp_stall,
   output logic                      disp_rtn_data_vld,
   output logic [63:0]               disp_rtn_data,
   output logic [NUM_CH-1:0]         ch_rst_n,
   output logic [47:0]               ch_addr,
   input  logic [NUM_CH-1:0]         ch_done,
   input  logic [NUM_CH*GVT_W-1:0]   ch_gvt,
   input  logic                      csr_rd_vld,
   input  logic [15:0]               csr_address,
   output logic                      csr_rd_ack,
   output logic [63:0]               csr_rd_data
);

   // state    | meaning
   // IDLE     | waiting for a caep00 launch
   // RUNNING  | channels released, collecting done pulses and GVT minimum
   // FINISHED | all enabled channels reported; result written to AEG[1]
   // TIMEOUT  | cycle limit reached with channels outstanding
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUNNING  = 2'd1,
      S_FINISHED = 2'd2,
      S_TIMEOUT  = 2'd3
   } state_t;

   localparam int NB = $clog2(NA);

   state_t              state_q, state_d;
   logic                caep00_q;
   logic [63:0]         aeg_q [NA];
   logic [63:0]         aeg_d [NA];
   logic [NUM_CH-1:0]   done_q, done_d;
   logic [NUM_CH-1:0]   en_q, en_d;
   logic [GVT_W-1:0]    min_q, min_d;
   logic [31:0]         cnt_q, cnt_d;
   logic                sticky_q, sticky_d;
   logic [2:0]          exc_q, exc_d;
   logic                rtn_vld_q;
   logic [63:0]         rtn_data_q, rtn_data_d;
   logic                csr_ack_q;
   logic [63:0]         csr_data_q, csr_data_d;
   logic [NUM_CH-1:0]   ch_rst_n_q, ch_rst_n_d;

   logic                caep00;
   logic                idx_ok;
   logic [NB-1:0]       idx_lo;
   logic [NUM_CH-1:0]   mask_raw;
   logic [NUM_CH-1:0]   new_done;
   logic [GVT_W-1:0]    min_fold;
   logic                all_done;
   logic                tmo_hit;
   logic                res_vld;
   logic [63:0]         res;

   assign caep00   = disp_inst_vld && (disp_inst == 5'd0);
   assign idx_ok   = disp_aeg_idx < 18'(NA);
   assign idx_lo   = disp_aeg_idx[NB-1:0];
   assign mask_raw = aeg_q[2][NUM_CH-1:0];
   assign new_done = ch_done & en_q & ~done_q;

   always_comb begin
      min_fold = min_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (new_done[i] && (ch_gvt[i*GVT_W +: GVT_W] < min_fold)) min_fold = ch_gvt[i*GVT_W +: GVT_W];
      end
      // Dones arriving this cycle count toward completion.
      all_done = ((done_q | new_done) & en_q) == en_q;
      tmo_hit  = (aeg_q[3] != 64'd0) && ({32'd0, cnt_q} == aeg_q[3] - 64'd1);
   end

   always_comb begin
      state_d  = state_q;
      done_d   = done_q;
      en_d     = en_q;
      min_d    = min_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      exc_d    = 3'b000;
      res_vld  = 1'b0;
      res      = 64'd0;
      case (state_q)
         S_IDLE: begin
            if (caep00_q) begin
               state_d  = S_RUNNING;
               done_d   = '0;
               cnt_d    = 32'd0;
               min_d    = '1;
               sticky_d = 1'b0;
               en_d     = (mask_raw == '0) ? '1 : mask_raw;
            end
         end
         S_RUNNING: begin
            cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
            done_d = done_q | new_done;
            min_d  = min_fold;
            if (all_done) begin
               state_d = S_FINISHED;
               res_vld = 1'b1;
               res     = {{(64-GVT_W){1'b0}}, min_fold};
            end else if (tmo_hit) begin
               state_d  = S_TIMEOUT;
               res_vld  = 1'b1;
               res      = '1;
               sticky_d = 1'b1;
               exc_d[2] = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ch_rst_n_d = (state_d == S_RUNNING) ? en_d : '0;
      exc_d[0]   = disp_inst_vld && (disp_inst != 5'd0);
      exc_d[1]   = (disp_aeg_rd || disp_aeg_wr) && !idx_ok;
   end

   always_comb begin
      aeg_d = aeg_q;
      if (res_vld) aeg_d[1] = res;
      // A dispatch write to AEG[1] overrides the run result.
      if (disp_aeg_wr && idx_ok) aeg_d[idx_lo] = disp_aeg_wr_data;
      rtn_data_d = (disp_aeg_rd && idx_ok) ? aeg_q[idx_lo] : 64'd0;
      csr_data_d = 64'd0;
      if (csr_rd_vld) begin
         case (csr_address)
            16'h0000: csr_data_d = {60'd0, state_q, 2'b00} | {63'd0, sticky_q};
            16'h0001: csr_data_d = aeg_q[1];
            16'h0002: csr_data_d = {{(64-NUM_CH){1'b0}}, done_q};
            16'h0003: csr_data_d = {32'd0, cnt_q};
            default:  csr_data_d = 64'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         caep00_q   <= 1'b0;
         for (int i = 0; i < NA; i++) aeg_q[i] <= 64'd0;
         done_q     <= '0;
         en_q       <= '0;
         min_q      <= '0;
         cnt_q      <= 32'd0;
         sticky_q   <= 1'b0;
         exc_q      <= 3'b000;
         rtn_vld_q  <= 1'b0;
         rtn_data_q <= 64'd0;
         csr_ack_q  <= 1'b0;
         csr_data_q <= 64'd0;
         ch_rst_n_q <= '0;
      end else begin
         state_q    <= state_d;
         caep00_q   <= caep00;
         aeg_q      <= aeg_d;
         done_q     <= done_d;
         en_q       <= en_d;
         min_q      <= min_d;
         cnt_q      <= cnt_d;
         sticky_q   <= sticky_d;
         exc_q      <= exc_d;
         rtn_vld_q  <= disp_aeg_rd;
         rtn_data_q <= rtn_data_d;
         csr_ack_q  <= csr_rd_vld;
         csr_data_q <= csr_data_d;
         ch_rst_n_q <= ch_rst_n_d;
      end
   end

   assign disp_aeg_cnt      = 18'(NA);
   assign disp_exception    = {13'd0, exc_q};
   assign disp_idle         = (state_q == S_IDLE) && !caep00_q;
   assign disp_stall        = (state_q != S_IDLE) || caep00 || caep00_q;
   assign disp_rtn_data_vld = rtn_vld_q;
   assign disp_rtn_data     = rtn_data_q;
   assign ch_rst_n          = ch_rst_n_q;
   assign ch_addr           = aeg_q[0][47:0];
   assign csr_rd_ack        = csr_ack_q;
   assign csr_rd_data       = csr_data_q;

endmodule

// File: tb/tb_pdes_ctrl.sv
// Randomized self-checking bench for pdes_ctrl against a run-level behavioural model.
module tb_pdes_ctrl;
   localparam int NUM_CH = 4;
   localparam int NA     = 8;
   localparam int GVT_W  = 14;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    disp_inst_vld = 1'b0;
   logic [4:0]              disp_inst = '0;
   logic [17:0]             disp_aeg_idx = '0;
   logic                    disp_aeg_rd = 1'b0;
   logic                    disp_aeg_wr = 1'b0;
   logic [63:0]             disp_aeg_wr_data = '0;
   logic [17:0]             disp_aeg_cnt;
   logic [15:0]             disp_exception;
   logic                    disp_idle, disp_stall;
   logic                    disp_rtn_data_vld;
   logic [63:0]             disp_rtn_data;
   logic [NUM_CH-1:0]       ch_rst_n;
   logic [47:0]             ch_addr;
   logic [NUM_CH-1:0]       ch_done = '0;
   logic [NUM_CH*GVT_W-1:0] ch_gvt = '0;
   logic                    csr_rd_vld = 1'b0;
   logic [15:0]             csr_address = '0;
   logic                    csr_rd_ack;
   logic [63:0]             csr_rd_data;

   int checks = 0;
   int failures = 0;
   logic [63:0] aeg_m [NA];

   pdes_ctrl #(.NUM_CH(NUM_CH), .NA(NA), .GVT_W(GVT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_inst_vld(disp_inst_vld), .disp_inst(disp_inst),
      .disp_aeg_idx(disp_aeg_idx), .disp_aeg_rd(disp_aeg_rd), .disp_aeg_wr(disp_aeg_wr),
      .disp_aeg_wr_data(disp_aeg_wr_data), .disp_aeg_cnt(disp_aeg_cnt),
      .disp_exception(disp_exception), .disp_idle(disp_idle), .disp_stall(disp_stall),
      .disp_rtn_data_vld(disp_rtn_data_vld), .disp_rtn_data(disp_rtn_data),
      .ch_rst_n(ch_rst_n), .ch_addr(ch_addr), .ch_done(ch_done), .ch_gvt(ch_gvt),
      .csr_rd_vld(csr_rd_vld), .csr_address(csr_address),
      .csr_rd_ack(csr_rd_ack), .csr_rd_data(csr_rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic aeg_wr(input logic [17:0] idx, input logic [63:0] data);
      disp_aeg_wr = 1'b1; disp_aeg_idx = idx; disp_aeg_wr_data = data;
      tick();
      disp_aeg_wr = 1'b0;
      if (idx < NA) aeg_m[idx] = data;
   endtask

   task automatic aeg_rd(input logic [17:0] idx, output logic vld, output logic [63:0] data,
                         output logic [15:0] exc);
      disp_aeg_rd = 1'b1; disp_aeg_idx = idx;
      tick();
      disp_aeg_rd = 1'b0;
      vld = disp_rtn_data_vld; data = disp_rtn_data; exc = disp_exception;
   endtask

   task automatic csr_rd(input logic [15:0] addr, output logic ack, output logic [63:0] data);
      csr_rd_vld = 1'b1; csr_address = addr;
      tick();
      csr_rd_vld = 1'b0;
      ack = csr_rd_ack; data = csr_rd_data;
   endtask

   task automatic start_run();
      disp_inst_vld = 1'b1; disp_inst = 5'd0;
      tick();
      disp_inst_vld = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({disp_idle, disp_stall, ch_rst_n, disp_exception, disp_rtn_data_vld, csr_rd_ack, ch_addr}
          !== {1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 48'h0}) begin
         failures++;
         $display("FAIL reset_outputs: got idle=%b stall=%b ch_rst_n=%h exc=%h rtn=%b ack=%b addr=%h expected idle=1 others 0",
                  disp_idle, disp_stall, ch_rst_n, disp_exception, disp_rtn_data_vld, csr_rd_ack, ch_addr);
      end
      checks++;
      if (disp_aeg_cnt !== 18'(NA)) begin
         failures++; $display("FAIL reset_aeg_cnt: got %0d expected %0d", disp_aeg_cnt, NA);
      end
      for (int i = 0; i < NA; i++) aeg_m[i] = 64'd0;
      #10 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_aeg_rw();
      logic vld; logic [63:0] d; logic [15:0] e;
      for (int i = 0; i < NA; i++) aeg_wr(18'(i), {$urandom, $urandom});
      for (int i = 0; i < NA; i++) begin
         aeg_rd(18'(i), vld, d, e);
         checks++;
         if ({vld, d, e} !== {1'b1, aeg_m[i], 16'h0}) begin
            failures++; $display("FAIL aeg_readback[%0d]: got vld=%b data=%h exc=%h expected 1 %h 0", i, vld, d, e, aeg_m[i]);
         end
      end
      checks++;
      if (ch_addr !== aeg_m[0][47:0]) begin
         failures++; $display("FAIL ch_addr: got %h expected %h", ch_addr, aeg_m[0][47:0]);
      end
      aeg_wr(18'(NA + 2), 64'hDEAD_BEEF_0000_0001);
      checks++;
      if (disp_exception !== 16'h0002) begin
         failures++; $display("FAIL bad_idx_write_exc: got %h expected 0002", disp_exception);
      end
      aeg_rd(18'd2, vld, d, e);
      checks++;
      if (d !== aeg_m[2]) begin
         failures++; $display("FAIL bad_idx_write_no_effect: got %h expected %h", d, aeg_m[2]);
      end
   endtask

   task automatic test_exceptions();
      logic vld; logic [63:0] d; logic [15:0] e;
      aeg_rd(18'(NA), vld, d, e);
      checks++;
      if ({vld, d, e} !== {1'b1, 64'd0, 16'h0002}) begin
         failures++; $display("FAIL bad_idx_read: got vld=%b data=%h exc=%h expected 1 0 0002", vld, d, e);
      end
      disp_inst_vld = 1'b1; disp_inst = 5'd3;
      tick();
      disp_inst_vld = 1'b0;
      checks++;
      if (disp_exception !== 16'h0001 || disp_idle !== 1'b1) begin
         failures++; $display("FAIL unimpl_inst: got exc=%h idle=%b expected 0001 1", disp_exception, disp_idle);
      end
      tick();
      checks++;
      if (disp_exception !== 16'h0000) begin
         failures++; $display("FAIL exc_one_cycle: got %h expected 0000", disp_exception);
      end
   endtask

   task automatic test_run_basic();
      logic ack; logic [63:0] d; logic vld; logic [15:0] e;
      int gv[4] = '{30, 12, 40, 25};
      aeg_wr(18'd2, 64'd0);
      aeg_wr(18'd3, 64'd0);
      start_run();
      checks++;
      if ({ch_rst_n, disp_stall, disp_idle} !== {4'hF, 1'b1, 1'b0}) begin
         failures++; $display("FAIL basic_running: got ch_rst_n=%h stall=%b idle=%b expected f 1 0", ch_rst_n, disp_stall, disp_idle);
      end
      for (int k = 0; k < 4; k++) begin
         ch_done = 4'(1 << k);
         ch_gvt = '0;
         ch_gvt[k*GVT_W +: GVT_W] = GVT_W'(gv[k]);
         tick();
         ch_done = '0;
         checks++;
         if (ch_rst_n !== ((k < 3) ? 4'hF : 4'h0)) begin
            failures++; $display("FAIL basic_progress[%0d]: got ch_rst_n=%h", k, ch_rst_n);
         end
      end
      csr_rd(16'h0, ack, d);
      checks++;
      if ({ack, d} !== {1'b1, 64'h8}) begin
         failures++; $display("FAIL basic_finished_state: got ack=%b data=%h expected 1 8", ack, d);
      end
      checks++;
      if (disp_idle !== 1'b1) begin
         failures++; $display("FAIL basic_idle_return: got %b expected 1", disp_idle);
      end
      aeg_rd(18'd1, vld, d, e);
      checks++;
      if (d !== 64'd12) begin
         failures++; $display("FAIL basic_min: got %0d expected 12", d);
      end
      csr_rd(16'h3, ack, d);
      checks++;
      if (d !== 64'd4) begin
         failures++; $display("FAIL basic_cycles: got %0d expected 4", d);
      end
   endtask

   task automatic test_simul_done();
      logic ack; logic [63:0] d; logic vld; logic [15:0] e;
      start_run();
      ch_done = 4'b0011;
      ch_gvt = {14'd0, 14'd0, 14'd9, 14'd9};
      tick();
      ch_done = 4'b1100;
      ch_gvt = {14'd5, 14'd7, 14'd0, 14'd0};
      tick();
      ch_done = '0;
      csr_rd(16'h0, ack, d);
      checks++;
      if (d !== 64'h8) begin
         failures++; $display("FAIL simul_finished: got %h expected 8", d);
      end
      tick();
      checks++;
      if ({disp_idle, ch_rst_n} !== {1'b1, 4'h0}) begin
         failures++; $display("FAIL simul_single_finish: got idle=%b ch_rst_n=%h expected 1 0", disp_idle, ch_rst_n);
      end
      aeg_rd(18'd1, vld, d, e);
      checks++;
      if (d !== 64'd5) begin
         failures++; $display("FAIL simul_min: got %0d expected 5", d);
      end
   endtask

   task automatic test_mask();
      logic ack; logic [63:0] d; logic vld; logic [15:0] e;
      aeg_wr(18'd2, 64'h5);
      start_run();
      checks++;
      if (ch_rst_n !== 4'b0101) begin
         failures++; $display("FAIL mask_ch_rst_n: got %b expected 0101", ch_rst_n);
      end
      ch_done = 4'b0010; ch_gvt = {14'd0, 14'd0, 14'd1, 14'd0};
      tick();
      ch_done = 4'b0001; ch_gvt = {14'd0, 14'd0, 14'd0, 14'd20};
      tick();
      ch_done = 4'b0011; ch_gvt = {14'd0, 14'd0, 14'd1, 14'd2};
      tick();
      checks++;
      if (ch_rst_n !== 4'b0101) begin
         failures++; $display("FAIL mask_still_running: got %b expected 0101", ch_rst_n);
      end
      ch_done = 4'b0110; ch_gvt = {14'd0, 14'd17, 14'd1, 14'd0};
      tick();
      ch_done = '0;
      checks++;
      if (ch_rst_n !== 4'b0000) begin
         failures++; $display("FAIL mask_finish: got %b expected 0000", ch_rst_n);
      end
      tick();
      aeg_rd(18'd1, vld, d, e);
      checks++;
      if (d !== 64'd17) begin
         failures++; $display("FAIL mask_min: got %0d expected 17", d);
      end
      csr_rd(16'h2, ack, d);
      checks++;
      if (d !== 64'h5) begin
         failures++; $display("FAIL mask_done_mask: got %h expected 5", d);
      end
   endtask

   task automatic test_timeout();
      logic ack; logic [63:0] d; logic vld; logic [15:0] e;
      int n;
      aeg_wr(18'd2, 64'd0);
      aeg_wr(18'd3, 64'd100);
      start_run();
      ch_done = 4'b1110; ch_gvt = {14'd3, 14'd4, 14'd5, 14'd0};
      tick();
      ch_done = '0;
      n = 1;
      while (ch_rst_n !== 4'h0 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (n != 100) begin
         failures++; $display("FAIL timeout_cycle: got %0d expected 100", n);
      end
      checks++;
      if (disp_exception !== 16'h0004) begin
         failures++; $display("FAIL timeout_exc: got %h expected 0004", disp_exception);
      end
      csr_rd(16'h0, ack, d);
      checks++;
      if ({d, disp_exception} !== {64'hD, 16'h0}) begin
         failures++; $display("FAIL timeout_state: got csr=%h exc=%h expected d 0", d, disp_exception);
      end
      aeg_rd(18'd1, vld, d, e);
      checks++;
      if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         failures++; $display("FAIL timeout_result: got %h expected all-ones", d);
      end
      csr_rd(16'h0, ack, d);
      checks++;
      if (d !== 64'h1) begin
         failures++; $display("FAIL timeout_sticky: got %h expected 1", d);
      end
      csr_rd(16'h3, ack, d);
      checks++;
      if (d !== 64'd100) begin
         failures++; $display("FAIL timeout_cycles: got %0d expected 100", d);
      end
      aeg_wr(18'd3, 64'd0);
   endtask

   task automatic test_random_runs();
      logic ack; logic [63:0] d; logic vld; logic [15:0] e;
      for (int it = 0; it < 20; it++) begin
         logic [3:0] mask, en, dm, drv;
         logic [GVT_W-1:0] minv, g[NUM_CH];
         int n;
         mask = 4'($urandom_range(0, 15));
         en = (mask == 4'd0) ? 4'hF : mask;
         aeg_wr(18'd2, {$urandom, 28'($urandom), mask});
         start_run();
         dm = '0; minv = '1; n = 0;
         while (n < 40) begin
            drv = (n >= 30) ? 4'hF : 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            for (int i = 0; i < NUM_CH; i++) begin
               g[i] = GVT_W'($urandom);
               ch_gvt[i*GVT_W +: GVT_W] = g[i];
               if (drv[i] && en[i] && !dm[i]) begin
                  dm[i] = 1'b1;
                  if (g[i] < minv) minv = g[i];
               end
            end
            ch_done = drv;
            tick();
            ch_done = '0;
            n++;
            checks++;
            if (ch_rst_n !== (((dm & en) == en) ? 4'h0 : en)) begin
               failures++; $display("FAIL rand_ch_rst_n[%0d]: got %h mask %h done %h", it, ch_rst_n, en, dm);
            end
            if ((dm & en) == en) break;
         end
         tick();
         aeg_rd(18'd1, vld, d, e);
         checks++;
         if (d !== {50'd0, minv}) begin
            failures++; $display("FAIL rand_min[%0d]: got %0d expected %0d", it, d, minv);
         end
         csr_rd(16'h3, ack, d);
         checks++;
         if (d !== 64'(n)) begin
            failures++; $display("FAIL rand_cycles[%0d]: got %0d expected %0d", it, d, n);
         end
         csr_rd(16'h2, ack, d);
         checks++;
         if (d !== {60'd0, dm}) begin
            failures++; $display("FAIL rand_done_mask[%0d]: got %h expected %h", it, d, dm);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic ack; logic [63:0] d; logic vld; logic [15:0] e;
      aeg_wr(18'd2, 64'd0);
      start_run();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ch_rst_n, disp_idle, disp_stall} !== {4'h0, 1'b1, 1'b0}) begin
         failures++; $display("FAIL mid_run_reset: got ch_rst_n=%h idle=%b stall=%b expected 0 1 0", ch_rst_n, disp_idle, disp_stall);
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < NA; i++) aeg_m[i] = 64'd0;
      tick();
      csr_rd(16'h0, ack, d);
      checks++;
      if (d !== 64'h0) begin
         failures++; $display("FAIL mid_run_reset_state: got %h expected 0", d);
      end
      aeg_rd(18'd0, vld, d, e);
      checks++;
      if (d !== aeg_m[0]) begin
         failures++; $display("FAIL mid_run_reset_aeg: got %h expected %h", d, aeg_m[0]);
      end
   endtask

   initial begin
      test_reset();
      test_aeg_rw();
      test_exceptions();
      test_run_basic();
      test_simul_done();
      test_mask();
      test_timeout();
      test_random_runs();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
